// File: rtl/inv_cipher.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys fetched by index.
// Latency NR+1 edges from accept to o_tx_en; o_ready low while busy, no input queuing.
// Optional INV_CIPHER_ABORT_EN adds i_abort to drop an in-flight block.
module inv_cipher #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_tx_en,
  input  logic [127:0]     i_state,
`ifdef INV_CIPHER_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_ready,
  output logic [IDX_W-1:0] o_rk_idx,
  input  logic [127:0]     i_round_key,
  output logic             o_tx_en,
  output logic [127:0]     o_state
);

  typedef logic [127:0] block_t;
  typedef enum logic {IDLE, ROUND} fsm_t;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NR);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(NR - 1);

  // Inverse S-box, entry b at bits [2047-8b -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant k (k < 16) as a sum of xtime powers.
  function automatic logic [7:0] mulc(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mulc(a0, 4'he) ^ mulc(a1, 4'hb) ^ mulc(a2, 4'hd) ^ mulc(a3, 4'h9),
            mulc(a0, 4'h9) ^ mulc(a1, 4'he) ^ mulc(a2, 4'hb) ^ mulc(a3, 4'hd),
            mulc(a0, 4'hd) ^ mulc(a1, 4'h9) ^ mulc(a2, 4'he) ^ mulc(a3, 4'hb),
            mulc(a0, 4'hb) ^ mulc(a1, 4'hd) ^ mulc(a2, 4'h9) ^ mulc(a3, 4'he)};
  endfunction

  fsm_t             state_q, state_d;
  logic [IDX_W-1:0] rnd_q, rnd_d, idx_d;
  block_t           state_reg, sreg_d, out_d;
  logic             tx_d;
  logic             abort_req;

  block_t sr, sb, ark, mix;

`ifdef INV_CIPHER_ABORT_EN
  assign abort_req = i_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Row r of the output takes column (c - r) mod 4 of the input.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign sr[127-8*(r+4*c) -: 8] = state_reg[127-8*(r+4*((c+4-r)%4)) -: 8];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[127-8*i -: 8] = inv_sbox(sr[127-8*i -: 8]);
  end

  assign ark = sb ^ i_round_key;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mix[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  assign o_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    idx_d   = o_rk_idx;
    sreg_d  = state_reg;
    tx_d    = 1'b0;
    out_d   = o_state;
    case (state_q)
      IDLE: begin
        if (i_tx_en) begin
          sreg_d  = i_state ^ i_round_key;
          rnd_d   = IDX_FIRST;
          idx_d   = IDX_FIRST;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (abort_req) begin
          sreg_d  = '0;
          rnd_d   = '0;
          idx_d   = IDX_LAST;
          state_d = IDLE;
        end else if (rnd_q != '0) begin
          sreg_d = mix;
          rnd_d  = rnd_q - IDX_W'(1);
          idx_d  = rnd_q - IDX_W'(1);
        end else begin
          // Final round omits InvMixColumns and publishes the plaintext.
          out_d   = ark;
          tx_d    = 1'b1;
          idx_d   = IDX_LAST;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      rnd_q     <= '0;
      o_rk_idx  <= IDX_LAST;
      o_tx_en   <= 1'b0;
      o_state   <= '0;
      state_reg <= '0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      o_rk_idx  <= idx_d;
      o_tx_en   <= tx_d;
      o_state   <= out_d;
      state_reg <= sreg_d;
    end
  end

endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher: FIPS-197 vectors, random keys/blocks against a byte-level AES model.
module tb_inv_cipher;

  localparam int NR = 10;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clock = 1'b0;
  logic         reset;
  logic         tx_en;
  logic [127:0] state_in;
  logic         ready;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic         tx_out;
  logic [127:0] state_out;
`ifdef INV_CIPHER_ABORT_EN
  logic         abort;
`endif

  logic [127:0] rk_store [2][11];
  logic         bank;
  logic [7:0]   sbt [256];
  logic [7:0]   isb [256];
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clock = ~clock;

  always_comb begin
    round_key = '0;
    if (rk_idx <= 4'd10) round_key = rk_store[bank][rk_idx];
  end

  inv_cipher #(.NR(NR), .IDX_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_tx_en     (tx_en),
    .i_state     (state_in),
`ifdef INV_CIPHER_ABORT_EN
    .i_abort     (abort),
`endif
    .o_ready     (ready),
    .o_rk_idx    (rk_idx),
    .i_round_key (round_key),
    .o_tx_en     (tx_out),
    .o_state     (state_out)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbt[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  task automatic key_expand(input logic bk, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
        t ^= {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_store[bk][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_decrypt(input logic bk, input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   coef [4];
    logic [127:0] k, res;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    k = rk_store[bk][NR];
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = NR - 1; rnd >= 0; rnd--) begin
      k = rk_store[bk][rnd];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c-r+4)%4)];
      for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ k[127-8*i -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            t[r+4*c] = '0;
            for (int j = 0; j < 4; j++) t[r+4*c] ^= gmul(coef[(j-r+4)%4], s[j+4*c]);
          end
        s = t;
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one block, flooding tx_en with junk while busy; reports what was seen.
  task automatic run_block(input logic [127:0] ct, output logic [127:0] got,
                           output int lat, output int seq_bad, output logic stuck);
    int w;
    w = 0;
    seq_bad = 0;
    got = 'x;
    stuck = 1'b0;
    while (!ready && w < 20) begin
      tick();
      w++;
    end
    if (rk_idx !== 4'(NR)) seq_bad++;
    tx_en = 1'b1;
    state_in = ct;
    tick();
    lat = 0;
    while (!tx_out && lat < 30) begin
      if (rk_idx !== 4'(NR - 1 - lat) || ready !== 1'b0) seq_bad++;
      tx_en = 1'($urandom_range(0, 1));
      state_in = rnd128();
      tick();
      lat++;
    end
    tx_en = 1'b0;
    if (tx_out) begin
      got = state_out;
      if (rk_idx !== 4'(NR) || ready !== 1'b1) seq_bad++;
      tick();
      stuck = tx_out;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_en = 1'($urandom_range(0, 1));
      state_in = rnd128();
      tick();
      n_cmp += 4;
      if (tx_out !== 1'b0) begin n_err++; $display("FAIL reset_tx: got %b expected 0", tx_out); end
      if (state_out !== '0) begin n_err++; $display("FAIL reset_state: got %h expected 0", state_out); end
      if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
      if (rk_idx !== 4'(NR)) begin n_err++; $display("FAIL reset_idx: got %0d expected %0d", rk_idx, NR); end
    end
    tx_en = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fips(input logic bk, input logic [127:0] ct, input logic [127:0] pt, input string nm);
    logic [127:0] got;
    int lat, seq_bad;
    logic stuck;
    bank = bk;
    run_block(ct, got, lat, seq_bad, stuck);
    n_cmp += 4;
    if (got !== pt) begin n_err++; $display("FAIL %s_pt: got %h expected %h", nm, got, pt); end
    if (lat !== NR) begin n_err++; $display("FAIL %s_latency: got %0d expected %0d", nm, lat, NR); end
    if (seq_bad !== 0) begin n_err++; $display("FAIL %s_idx_seq: %0d bad cycles expected 0", nm, seq_bad); end
    if (stuck !== 1'b0) begin n_err++; $display("FAIL %s_pulse: tx still %b expected 0", nm, stuck); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp += 2;
      if (state_out !== PT_C1) begin n_err++; $display("FAIL hold_state: got %h expected %h", state_out, PT_C1); end
      if (tx_out !== 1'b0) begin n_err++; $display("FAIL hold_tx: got %b expected 0", tx_out); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] expq[$];
    logic [127:0] exp_pt;
    int cyc, last_tx, done;
    logic sel;
    cyc = 0; last_tx = -1; done = 0; sel = 1'b0;
    tx_en = 1'b1;
    while (done < 4 && cyc < 80) begin
      if (ready) begin
        bank = sel;
        state_in = sel ? CT_B : CT_C1;
        expq.push_back(sel ? PT_B : PT_C1);
        sel = ~sel;
      end else begin
        state_in = rnd128();
      end
      tick();
      cyc++;
      if (tx_out) begin
        exp_pt = expq.pop_front();
        n_cmp++;
        if (state_out !== exp_pt) begin n_err++; $display("FAIL b2b_pt: got %h expected %h", state_out, exp_pt); end
        if (last_tx >= 0) begin
          n_cmp++;
          if (cyc - last_tx !== NR + 1) begin
            n_err++; $display("FAIL b2b_spacing: got %0d expected %0d", cyc - last_tx, NR + 1);
          end
        end
        last_tx = cyc;
        done++;
      end
    end
    tx_en = 1'b0;
    n_cmp++;
    if (done !== 4) begin n_err++; $display("FAIL b2b_count: got %0d expected 4", done); end
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [127:0] got;
    int lat, seq_bad;
    logic stuck;
    bank = 1'b0;
    tx_en = 1'b1;
    state_in = CT_C1;
    tick();
    tx_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp += 4;
    if (tx_out !== 1'b0) begin n_err++; $display("FAIL midrst_tx: got %b expected 0", tx_out); end
    if (state_out !== '0) begin n_err++; $display("FAIL midrst_state: got %h expected 0", state_out); end
    if (ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", ready); end
    if (rk_idx !== 4'(NR)) begin n_err++; $display("FAIL midrst_idx: got %0d expected %0d", rk_idx, NR); end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (tx_out) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_err++; $display("FAIL midrst_ghost: got %0d pulses expected 0", pulses); end
    run_block(CT_C1, got, lat, seq_bad, stuck);
    n_cmp += 2;
    if (got !== PT_C1) begin n_err++; $display("FAIL midrst_after: got %h expected %h", got, PT_C1); end
    if (lat !== NR) begin n_err++; $display("FAIL midrst_latency: got %0d expected %0d", lat, NR); end
  endtask

`ifdef INV_CIPHER_ABORT_EN
  task automatic test_abort();
    logic [127:0] prev;
    int pulses;
    prev = state_out;
    bank = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      tx_en = 1'b1;
      state_in = CT_C1;
      tick();
      tx_en = 1'b0;
      // pass 0: abort at round 3; pass 1: abort on the final-round edge
      for (int i = 0; i < (pass == 0 ? 6 : 9); i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp += 4;
      if (tx_out !== 1'b0) begin n_err++; $display("FAIL abort%0d_tx: got %b expected 0", pass, tx_out); end
      if (state_out !== prev) begin n_err++; $display("FAIL abort%0d_state: got %h expected %h", pass, state_out, prev); end
      if (ready !== 1'b1) begin n_err++; $display("FAIL abort%0d_ready: got %b expected 1", pass, ready); end
      if (rk_idx !== 4'(NR)) begin n_err++; $display("FAIL abort%0d_idx: got %0d expected %0d", pass, rk_idx, NR); end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (tx_out) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin n_err++; $display("FAIL abort%0d_ghost: got %0d pulses expected 0", pass, pulses); end
    end
  endtask
`endif

  task automatic test_random();
    logic [127:0] ct, exp_pt, got;
    int lat, seq_bad;
    logic stuck;
    for (int n = 0; n < 6; n++) begin
      key_expand(1'b1, rnd128());
      bank = 1'b1;
      ct = rnd128();
      exp_pt = model_decrypt(1'b1, ct);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      run_block(ct, got, lat, seq_bad, stuck);
      n_cmp += 3;
      if (got !== exp_pt) begin n_err++; $display("FAIL rand%0d_pt: got %h expected %h", n, got, exp_pt); end
      if (lat !== NR) begin n_err++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, NR); end
      if (seq_bad !== 0) begin n_err++; $display("FAIL rand%0d_idx_seq: %0d bad cycles expected 0", n, seq_bad); end
    end
  endtask

  initial begin
    reset = 1'b0;
    tx_en = 1'b0;
    state_in = '0;
    bank = 1'b0;
`ifdef INV_CIPHER_ABORT_EN
    abort = 1'b0;
`endif
    build_tables();
    key_expand(1'b0, KEY_C1);
    key_expand(1'b1, KEY_B);
    test_reset();
    test_fips(1'b0, CT_C1, PT_C1, "fips_c1");
    test_hold();
    test_fips(1'b1, CT_B, PT_B, "fips_b");
    test_back_to_back();
    test_reset_mid();
`ifdef INV_CIPHER_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
